// File: rtl/divider_pkg.sv
// Shared definitions for the fixed-point divider: FSM state codes, iteration count
// and saturation constants (constants are 64 bits wide and sliced from the top by users).
package divider_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Users take the top DATA_WIDTH bits, so DATA_WIDTH may not exceed 64.
  localparam logic [63:0] MAX_POS = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;

  function automatic int n_iter(input int data_width, input int frac);
    return data_width + frac;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring division step: shift the next dividend bit into the remainder,
// compare against the divisor and subtract when it fits.
module divider_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_rem,
  input  logic                  i_bit,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic [DATA_WIDTH-1:0] o_rem,
  output logic                  o_qbit
);

  logic [DATA_WIDTH:0] w_shift;
  logic [DATA_WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign o_qbit  = (w_shift >= {1'b0, i_divisor});
  // When the bit is 0 the shifted value is below the divisor, so it fits DATA_WIDTH bits.
  assign o_rem   = o_qbit ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];

endmodule

// File: rtl/divider.sv
// Signed Q(DATA_WIDTH-FRAC).FRAC sequential divider, one quotient bit per cycle,
// with zero-divisor and saturation flags. Define DIVIDER_ROUND_EN for round-half-away-from-zero.
module divider
  import divider_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] FP_in1,
  input  logic [DATA_WIDTH-1:0] FP_in2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] FP_out,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int N  = n_iter(DATA_WIDTH, FRAC);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0]         L_LAST    = CW'(N - 1);
  localparam logic [DATA_WIDTH-1:0] L_MAX_POS = MAX_POS[63 -: DATA_WIDTH];
  localparam logic [DATA_WIDTH-1:0] L_MIN_NEG = MIN_NEG[63 -: DATA_WIDTH];
  localparam logic [N:0] L_POS_LIM = {{(N + 1 - DATA_WIDTH){1'b0}}, L_MAX_POS};
  localparam logic [N:0] L_NEG_LIM = {{(N + 1 - DATA_WIDTH){1'b0}}, L_MIN_NEG};

  logic [1:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic [N-1:0]          r_dvd;
  logic [DATA_WIDTH-1:0] r_dvs;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [N-2:0]          r_quot;
  logic                  r_sign;
  logic [DATA_WIDTH-1:0] r_fp_out;
  logic                  r_dbz;
  logic                  r_ovf;

  logic [DATA_WIDTH-1:0] w_mag1;
  logic [DATA_WIDTH-1:0] w_mag2;
  logic [DATA_WIDTH-1:0] w_rem_next;
  logic                  w_qbit;
  logic [N-1:0]          w_qfull;
  logic                  w_round;
  logic [N:0]            w_qmag;
  logic                  w_ovf;
  logic [DATA_WIDTH-1:0] w_low;
  logic [DATA_WIDTH-1:0] w_result;

  assign w_mag1 = FP_in1[DATA_WIDTH-1] ? -FP_in1 : FP_in1;
  assign w_mag2 = FP_in2[DATA_WIDTH-1] ? -FP_in2 : FP_in2;

  divider_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[N-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  // Final result is formed from the step output so DONE follows the last iteration directly.
  assign w_qfull = {r_quot, w_qbit};
`ifdef DIVIDER_ROUND_EN
  assign w_round = ({w_rem_next, 1'b0} >= {1'b0, r_dvs});
`else
  assign w_round = 1'b0;
`endif
  assign w_qmag   = {1'b0, w_qfull} + {{N{1'b0}}, w_round};
  assign w_ovf    = r_sign ? (w_qmag > L_NEG_LIM) : (w_qmag > L_POS_LIM);
  assign w_low    = w_qmag[DATA_WIDTH-1:0];
  assign w_result = w_ovf  ? (r_sign ? L_MIN_NEG : L_MAX_POS)
                           : (r_sign ? -w_low : w_low);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_sign   <= 1'b0;
      r_fp_out <= '0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign <= FP_in1[DATA_WIDTH-1] ^ FP_in2[DATA_WIDTH-1];
            r_dvd  <= {w_mag1, {FRAC{1'b0}}};
            r_dvs  <= w_mag2;
            r_rem  <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            if (FP_in2 == '0) begin
              r_state  <= ST_DONE;
              r_dbz    <= 1'b1;
              r_fp_out <= FP_in1[DATA_WIDTH-1] ? L_MIN_NEG : L_MAX_POS;
            end else begin
              r_state  <= ST_CALC;
              r_dbz    <= 1'b0;
              r_fp_out <= '0;
            end
          end
        end
        ST_CALC: begin
          r_dvd  <= {r_dvd[N-2:0], 1'b0};
          r_rem  <= w_rem_next;
          r_quot <= w_qfull[N-2:0];
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == L_LAST) begin
            r_state  <= ST_DONE;
            r_fp_out <= w_result;
            r_ovf    <= w_ovf;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign FP_out      = r_fp_out;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: vector table with latency/flag checks, plus output hold,
// pop-without-accept and mid-calculation reset sequences. Honours DIVIDER_ROUND_EN.
module tb_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] FP_in1;
  logic [31:0] FP_in2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] FP_out;
  logic        div_by_zero;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  divider #(.DATA_WIDTH(32), .FRAC(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .FP_in1      (FP_in1),
    .FP_in2      (FP_in2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .FP_out      (FP_out),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIVIDER_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Present a pair for one cycle, then scramble the inputs and count cycles to out_valid.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    FP_in1   = a;
    FP_in2   = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    FP_in1   = $urandom;
    FP_in2   = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Pop the result while offering a new pair, which must not be taken.
  task automatic pop_result();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    FP_in1    = 32'h0001_0000;
    FP_in2    = 32'h0001_0000;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("in_ready_after_pop", {31'd0, in_ready}, 32'd1);
    chk("out_valid_after_pop", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [31:0] held;

    vecs[0]  = '{32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, 49};
    vecs[1]  = '{32'hFFFF_0000, 32'h0004_0000, 32'hFFFF_C000, 1'b0, 1'b0, 49};
    vecs[2]  = '{32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
    vecs[3]  = '{32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 1};
    vecs[4]  = '{32'h7FFF_0000, 32'h0000_0100, 32'h7FFF_FFFF, 1'b0, 1'b1, 49};
    vecs[5]  = '{32'h0002_0000, 32'h0003_0000, RND ? 32'h0000_AAAB : 32'h0000_AAAA, 1'b0, 1'b0, 49};
    vecs[6]  = '{32'hFFFE_8000, 32'h0000_8000, 32'hFFFD_0000, 1'b0, 1'b0, 49};
    vecs[7]  = '{32'h0000_0000, 32'h0005_0000, 32'h0000_0000, 1'b0, 1'b0, 49};
    vecs[8]  = '{32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 49};
    vecs[9]  = '{32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, 49};
    vecs[10] = '{32'h0000_0001, 32'h0002_0000, RND ? 32'h0000_0001 : 32'h0000_0000, 1'b0, 1'b0, 49};
    vecs[11] = '{32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0, 49};
    vecs[12] = '{32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
    vecs[13] = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 1};
    vecs[14] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 49};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    FP_in1    = '0;
    FP_in2    = '0;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_fp_out", FP_out, 32'd0);
    chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_div(vecs[i].a, vecs[i].b, lat);
      $display("div %h / %h -> %h dbz=%b ovf=%b lat=%0d", vecs[i].a, vecs[i].b,
               FP_out, div_by_zero, overflow, lat);
      chk($sformatf("v%0d_fp_out", i), FP_out, vecs[i].exp);
      chk($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
      chk($sformatf("v%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].ovf});
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_in_ready_done", i), {31'd0, in_ready}, 32'd0);
      pop_result();
    end

    // Result must stay put while the consumer stalls.
    do_div(32'h0003_0000, 32'h0002_0000, lat);
    held = FP_out;
    $display("hold %h / %h -> %h lat=%0d", 32'h0003_0000, 32'h0002_0000, held, lat);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("hold_fp_out", FP_out, 32'h0001_8000);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    pop_result();

    // Reset in the middle of a calculation discards it.
    @(negedge clk);
    FP_in1   = 32'h7FFF_0000;
    FP_in2   = 32'h0000_0100;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midreset_fp_out", FP_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("midreset_no_result", seen, 32'd0);
    $display("reset mid-calc, stray results=%0d", seen);

    do_div(32'hFFFF_0000, 32'h0004_0000, lat);
    $display("div %h / %h -> %h dbz=%b ovf=%b lat=%0d", 32'hFFFF_0000, 32'h0004_0000,
             FP_out, div_by_zero, overflow, lat);
    chk("post_reset_fp_out", FP_out, 32'hFFFF_C000);
    chk("post_reset_latency", lat, 32'd49);
    chk("post_reset_ovf", {31'd0, overflow}, 32'd0);
    pop_result();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the operand and result width in bits.
REQ-002 SHALL have parameter FRAC, default 16, the number of fractional bits of the signed two's-complement fixed-point format (Q(DATA_WIDTH-FRAC).FRAC).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, dividend/divisor pair valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept a pair.
REQ-007 SHALL have port FP_in1, input, DATA_WIDTH, the dividend.
REQ-008 SHALL have port FP_in2, input, DATA_WIDTH, the divisor.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port FP_out, output, DATA_WIDTH, the quotient.
REQ-012 SHALL have port div_by_zero, output, 1, the current result came from a zero divisor.
REQ-013 SHALL have port overflow, output, 1, the current result saturated.

Function
REQ-014 SHALL implement the FSM states IDLE, CALC and DONE; in_ready = (state == IDLE).
REQ-015 SHALL accept a pair on a rising edge with in_valid && in_ready, latching |FP_in1| << FRAC, |FP_in2| and sign = sign1 XOR sign2.
REQ-016 SHALL, when FP_in2 is nonzero, go IDLE->CALC and run N = DATA_WIDTH+FRAC restoring shift/subtract iterations, one quotient bit per cycle, MSB first.
REQ-017 SHALL go CALC->DONE after the Nth iteration, so out_valid rises exactly N+1 cycles after the accepting edge (49 cycles at defaults).
REQ-018 SHALL, when FP_in2 == 0, go IDLE->DONE directly; out_valid rises 1 cycle after acceptance, div_by_zero=1, FP_out = max positive (or most negative if FP_in1 < 0; 0 -> max positive).
REQ-019 SHALL truncate the quotient toward zero, then apply the sign; a zero magnitude SHALL yield +0.
REQ-020 SHALL saturate when the magnitude exceeds 2^(DATA_WIDTH-1)-1 (positive) or 2^(DATA_WIDTH-1) (negative), output 0x7FF..F / 0x800..0, and set overflow=1.
REQ-021 SHALL hold FP_out, div_by_zero and overflow stable in DONE while out_ready=0.
REQ-022 SHALL go DONE->IDLE on out_valid && out_ready; in_valid in that same cycle SHALL NOT be accepted (in_ready is 0 in DONE).
REQ-023 SHALL ignore FP_in1/FP_in2 changes after acceptance.

Reset
REQ-024 SHALL on rst_n=0 immediately enter IDLE and clear out_valid, FP_out, div_by_zero, overflow, the iteration counter and all datapath registers; in_ready=1 while in IDLE.
REQ-025 SHALL abandon any in-flight division on a reset mid-CALC or mid-DONE, producing no result for it.

Configuration
REQ-026 SHALL use the macro DIVIDER_ROUND_EN: when defined, after the last iteration the magnitude is incremented if 2*remainder >= |divisor| (round half away from zero), before saturation; when undefined, truncation per REQ-019; latency is identical either way.

Structure
REQ-027 SHALL place the state enumeration, the N iteration-count function and the saturation constants (MAX_POS, MIN_NEG) in shared package divider_pkg.
REQ-028 SHALL isolate one restoring step (shift remainder, compare, subtract, emit quotient bit) in combinational sub-module divider_step.

Verification
REQ-029 SHALL cover: 0x00030000 / 0x00020000 -> FP_out 0x00018000, flags 0, out_valid 49 cycles after acceptance.
REQ-030 SHALL cover: 0xFFFF0000 / 0x00040000 -> FP_out 0xFFFFC000, flags 0.
REQ-031 SHALL cover: 0x00010000 / 0x00000000 -> FP_out 0x7FFFFFFF, div_by_zero=1, out_valid 1 cycle after acceptance; 0xFFFF0000 / 0 -> 0x80000000.
REQ-032 SHALL cover: 0x7FFF0000 / 0x00000100 -> FP_out 0x7FFFFFFF, overflow=1.
REQ-033 SHALL cover: 0x00020000 / 0x00030000 -> 0x0000AAAA without DIVIDER_ROUND_EN, 0x0000AAAB with it.
REQ-034 SHALL cover: out_ready held 0 for 10 cycles in DONE -> FP_out stable, in_ready=0; rst_n pulsed low mid-CALC -> out_valid=0, in_ready=1, and the next division is correct.
